// File: rtl/aes_avl_ctrl.sv
// Avalon-MM register front end and start/done sequencer for an AES core.
// Optional RUN watchdog is compiled in with macro AES_TIMEOUT_EN.
module aes_avl_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AVL_READ,
  input  logic         AVL_WRITE,
  input  logic         AVL_CS,
  input  logic [3:0]   AVL_BYTE_EN,
  input  logic [3:0]   AVL_ADDR,
  input  logic [31:0]  AVL_WRITEDATA,
  output logic [31:0]  AVL_READDATA,
  output logic [31:0]  EXPORT_DATA,
  output logic         AES_START,
  input  logic         AES_DONE,
  output logic [127:0] AES_KEY,
  output logic [127:0] AES_MSG_ENC,
  input  logic [127:0] AES_MSG_DEC
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_e;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e              state_q, state_d;
  logic [3:0][31:0]    key_q, key_d;
  logic [3:0][31:0]    enc_q, enc_d;
  logic [3:0][31:0]    dec_q, dec_d;
  logic [127:0]        hkey_q, hkey_d;
  logic [127:0]        henc_q, henc_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                done_q, done_d;
  logic                tout_q, tout_d;
  logic                start_q, start_d;
  logic                wr_en, rd_en, ctrl_wr, start_req, clr_req, busy;

`ifdef AES_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]       timer_q, timer_d;
`endif

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  assign wr_en     = AVL_CS && AVL_WRITE;
  assign rd_en     = AVL_CS && AVL_READ;
  assign ctrl_wr   = wr_en && (AVL_ADDR == 4'd14) && AVL_BYTE_EN[0];
  assign start_req = ctrl_wr && AVL_WRITEDATA[0];
  assign clr_req   = ctrl_wr && AVL_WRITEDATA[1];
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    enc_d   = enc_q;
    dec_d   = dec_q;
    hkey_d  = hkey_q;
    henc_d  = henc_q;
    rdata_d = rdata_q;
    done_d  = done_q;
    tout_d  = tout_q;
`ifdef AES_TIMEOUT_EN
    timer_d = timer_q;
`endif

    // KEY/ENC always writable; the hold registers isolate the running operation
    if (wr_en && AVL_ADDR[3:2] == 2'b00)
      key_d[AVL_ADDR[1:0]] = merge_bytes(key_q[AVL_ADDR[1:0]], AVL_WRITEDATA, AVL_BYTE_EN);
    if (wr_en && AVL_ADDR[3:2] == 2'b01)
      enc_d[AVL_ADDR[1:0]] = merge_bytes(enc_q[AVL_ADDR[1:0]], AVL_WRITEDATA, AVL_BYTE_EN);

    if (clr_req) done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = LOAD;
          done_d  = 1'b0;
          tout_d  = 1'b0;
        end
      end
      LOAD: begin
        hkey_d  = {key_q[0], key_q[1], key_q[2], key_q[3]};
        henc_d  = {enc_q[0], enc_q[1], enc_q[2], enc_q[3]};
        state_d = RUN;
`ifdef AES_TIMEOUT_EN
        timer_d = TW'(TIMEOUT_CYCLES - 1);
`endif
      end
      RUN: begin
        // done capture is evaluated after the clear so a coincident set wins
        if (AES_DONE) begin
          dec_d[0] = AES_MSG_DEC[127:96];
          dec_d[1] = AES_MSG_DEC[95:64];
          dec_d[2] = AES_MSG_DEC[63:32];
          dec_d[3] = AES_MSG_DEC[31:0];
          done_d   = 1'b1;
          state_d  = DRAIN;
        end
`ifdef AES_TIMEOUT_EN
        else if (timer_q == '0) begin
          tout_d  = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
`endif
      end
      DRAIN: begin
        if (!AES_DONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    start_d = (state_d == RUN);

    if (rd_en) begin
      case (AVL_ADDR)
        4'd0, 4'd1, 4'd2, 4'd3:   rdata_d = key_q[AVL_ADDR[1:0]];
        4'd4, 4'd5, 4'd6, 4'd7:   rdata_d = enc_q[AVL_ADDR[1:0]];
        4'd8, 4'd9, 4'd10, 4'd11: rdata_d = dec_q[AVL_ADDR[1:0]];
        4'd13:                    rdata_d = {29'd0, tout_q, done_q, busy};
        default:                  rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      key_q   <= '0;
      enc_q   <= '0;
      dec_q   <= '0;
      hkey_q  <= '0;
      henc_q  <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      start_q <= 1'b0;
`ifdef AES_TIMEOUT_EN
      timer_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      enc_q   <= enc_d;
      dec_q   <= dec_d;
      hkey_q  <= hkey_d;
      henc_q  <= henc_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
      start_q <= start_d;
`ifdef AES_TIMEOUT_EN
      timer_q <= timer_d;
`endif
    end
  end

  assign AVL_READDATA = rdata_q;
  assign EXPORT_DATA  = {key_q[0][31:16], key_q[3][15:0]};
  assign AES_START    = start_q;
  assign AES_KEY      = hkey_q;
  assign AES_MSG_ENC  = henc_q;

endmodule

// File: tb/tb_aes_avl_ctrl.sv
// Self-checking bench for aes_avl_ctrl: word-level register model plus a simple AES core responder.
module tb_aes_avl_ctrl;
  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         AVL_READ = 1'b0, AVL_WRITE = 1'b0, AVL_CS = 1'b0;
  logic [3:0]   AVL_BYTE_EN = '0, AVL_ADDR = '0;
  logic [31:0]  AVL_WRITEDATA = '0;
  logic [31:0]  AVL_READDATA, EXPORT_DATA;
  logic         AES_START;
  logic         AES_DONE = 1'b0;
  logic [127:0] AES_KEY, AES_MSG_ENC;
  logic [127:0] AES_MSG_DEC = '0;

  aes_avl_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RESET(RESET), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .EXPORT_DATA(EXPORT_DATA), .AES_START(AES_START),
    .AES_DONE(AES_DONE), .AES_KEY(AES_KEY), .AES_MSG_ENC(AES_MSG_ENC), .AES_MSG_DEC(AES_MSG_DEC));

  always #5 CLK = ~CLK;

  int errors = 0, checks = 0;

  // reference model state
  logic [31:0]  m_key[4], m_enc[4], m_dec[4];
  bit           m_done, m_to, m_busy;
  logic [127:0] m_hold_key, m_hold_enc;

  // AES core stand-in: raises DONE five cycles into a start, holds it until start drops
  bit           core_en = 1'b1;
  logic [127:0] core_resp = '0;
  int           core_cnt = 0;
  int           ops = 0;
  logic         start_prev = 1'b0;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      AES_DONE   <= 1'b0;
      core_cnt   <= 0;
      start_prev <= 1'b0;
    end else begin
      start_prev <= AES_START;
      if (AES_START && !start_prev) ops <= ops + 1;
      if (AES_START && core_en) begin
        core_cnt <= core_cnt + 1;
        if (core_cnt == 4) begin
          AES_DONE    <= 1'b1;
          AES_MSG_DEC <= core_resp;
        end
      end else if (!AES_START) begin
        core_cnt <= 0;
        AES_DONE <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input int a);
    if (a < 4)       return m_key[a];
    else if (a < 8)  return m_enc[a-4];
    else if (a < 12) return m_dec[a-8];
    else if (a == 13) return {29'd0, m_to, m_done, m_busy};
    else return 32'd0;
  endfunction

  function automatic logic [31:0] m_export();
    return {m_key[0][31:16], m_key[3][15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin m_key[i] = '0; m_enc[i] = '0; m_dec[i] = '0; end
    m_done = 0; m_to = 0; m_busy = 0; m_hold_key = '0; m_hold_enc = '0;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    @(negedge CLK);
    AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = a[3:0]; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    @(negedge CLK);
    AVL_CS = 0; AVL_WRITE = 0; AVL_BYTE_EN = '0;
    if (a < 4) m_key[a] = merge(m_key[a], d, be);
    else if (a < 8) m_enc[a-4] = merge(m_enc[a-4], d, be);
    else if (a == 14 && be[0]) begin
      if (d[0] && !m_busy) begin
        m_busy = 1; m_done = 0; m_to = 0;
        m_hold_key = {m_key[0], m_key[1], m_key[2], m_key[3]};
        m_hold_enc = {m_enc[0], m_enc[1], m_enc[2], m_enc[3]};
      end
      if (d[1]) m_done = 0;
    end
  endtask

  task automatic rd_chk(input int a, input string tag);
    @(negedge CLK);
    AVL_CS = 1; AVL_READ = 1; AVL_ADDR = a[3:0];
    @(negedge CLK);
    AVL_CS = 0; AVL_READ = 0;
    check(tag, {96'd0, AVL_READDATA}, {96'd0, m_read(a)});
  endtask

  // wait for the operation to finish; model then records the result
  task automatic wait_done(input logic [127:0] resp);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (!AES_START && !AES_DONE) begin ok = 1; break; end
    end
    check("op_complete", {127'd0, ok}, 128'd1);
    repeat (2) @(negedge CLK);
    m_busy = 0; m_done = 1;
    for (int w = 0; w < 4; w++) m_dec[w] = resp[127-32*w -: 32];
  endtask

  task automatic run_op(input logic [127:0] key, input logic [127:0] enc, input logic [127:0] resp);
    int ops0;
    for (int w = 0; w < 4; w++) begin
      wr(w, key[127-32*w -: 32], 4'hf);
      wr(4 + w, enc[127-32*w -: 32], 4'hf);
    end
    core_resp = resp;
    ops0 = ops;
    wr(14, 32'h1, 4'hf);
    check("latency_load_start_low", {127'd0, AES_START}, 128'd0);
    @(negedge CLK);
    check("latency_run_start_high", {127'd0, AES_START}, 128'd1);
    check("aes_key", AES_KEY, m_hold_key);
    check("aes_msg_enc", AES_MSG_ENC, m_hold_enc);
    wait_done(resp);
    for (int w = 0; w < 4; w++) rd_chk(8 + w, "dec_word");
    rd_chk(13, "status_done");
    check("single_op", ops, ops0 + 1);
  endtask

  initial begin
    int n, ops0;
    logic [31:0] last;
    logic [127:0] k, e, r, old_key;
    m_reset();
    repeat (3) @(negedge CLK);
    RESET = 0;
    @(negedge CLK);
    check("rst_aes_start", {127'd0, AES_START}, 128'd0);
    check("rst_aes_key", AES_KEY, 128'd0);
    check("rst_aes_enc", AES_MSG_ENC, 128'd0);
    check("rst_readdata", {96'd0, AVL_READDATA}, 128'd0);
    check("rst_export", {96'd0, EXPORT_DATA}, 128'd0);
    for (int a = 0; a < 14; a++) rd_chk(a, "rst_reg");

    // byte enables
    wr(0, 32'hffffffff, 4'b0101);
    rd_chk(0, "byte_en_word0");
    check("byte_en_export", {96'd0, EXPORT_DATA}, {96'd0, m_export()});
    last = AVL_READDATA;
    repeat (3) @(negedge CLK);
    check("readdata_hold", {96'd0, AVL_READDATA}, {96'd0, last});

    // random register traffic including ignored addresses
    for (int i = 0; i < 24; i++) begin
      wr($urandom_range(0, 13), $urandom, 4'($urandom_range(0, 15)));
      rd_chk($urandom_range(0, 13), "rand_reg");
      check("rand_export", {96'd0, EXPORT_DATA}, {96'd0, m_export()});
    end

    // known-answer run, then randomized runs
    run_op(128'h000102030405060708090a0b0c0d0e0f, 128'hdaec3055df058e1c39e814ea76f6747e,
           128'h0123456789abcdeffedcba9876543210);
    for (int i = 0; i < 3; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      e = {$urandom, $urandom, $urandom, $urandom};
      r = {$urandom, $urandom, $urandom, $urandom};
      run_op(k, e, r);
    end

    // clear done
    wr(14, 32'h2, 4'hf);
    rd_chk(13, "status_cleared");

    // busy isolation
    run_op(128'h000102030405060708090a0b0c0d0e0f, 128'hdaec3055df058e1c39e814ea76f6747e,
           128'h0123456789abcdeffedcba9876543210);
    old_key = m_hold_key;
    r = {$urandom, $urandom, $urandom, $urandom};
    core_resp = r;
    ops0 = ops;
    wr(14, 32'h1, 4'hf);
    @(negedge CLK);
    wr(0, 32'hdeadbeef, 4'hf);
    wr(14, 32'h1, 4'hf);
    check("busy_hold_key", AES_KEY, old_key);
    check("busy_hold_key_word0", {96'd0, AES_KEY[127:96]}, {96'd0, 32'h00010203});
    wait_done(r);
    rd_chk(0, "busy_key_word0_regfile");
    rd_chk(13, "busy_status");
    repeat (20) @(negedge CLK);
    check("busy_single_op", ops, ops0 + 1);

    // reset two cycles into RUN
    wr(14, 32'h1, 4'hf);
    repeat (3) @(negedge CLK);
    check("pre_reset_running", {127'd0, AES_START}, 128'd1);
    RESET = 1;
    #1;
    check("reset_async_start", {127'd0, AES_START}, 128'd0);
    check("reset_async_readdata", {96'd0, AVL_READDATA}, 128'd0);
    m_reset();
    @(negedge CLK);
    RESET = 0;
    @(negedge CLK);
    check("post_reset_start", {127'd0, AES_START}, 128'd0);
    check("post_reset_key", AES_KEY, 128'd0);
    rd_chk(13, "post_reset_status");
    for (int a = 8; a < 12; a++) rd_chk(a, "post_reset_dec");

    // watchdog: the core never answers
    r = {$urandom, $urandom, $urandom, $urandom};
    for (int w = 0; w < 4; w++) m_dec[w] = '0;
    core_en = 0;
    wr(14, 32'h1, 4'hf);
    n = 0;
    repeat (100) begin
      if (AES_START) n++;
      @(negedge CLK);
    end
`ifdef AES_TIMEOUT_EN
    check("timeout_run_cycles", n, 8);
    m_busy = 0; m_to = 1;
`else
    check("no_timeout_run_cycles", n, 99);
`endif
    rd_chk(13, "timeout_status");
    for (int a = 8; a < 12; a++) rd_chk(a, "timeout_dec_unchanged");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_avl_ctrl.md
AES_AVL_CTRL -- requirements
Module: aes_avl_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: cycles in RUN before abort; used only with AES_TIMEOUT_EN.
REQ-002 SHALL have port CLK, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port AVL_READ, input, 1 bit: Avalon-MM read strobe.
REQ-005 SHALL have port AVL_WRITE, input, 1 bit: Avalon-MM write strobe.
REQ-006 SHALL have port AVL_CS, input, 1 bit: chip select; strobes are ignored while it is low.
REQ-007 SHALL have port AVL_BYTE_EN, input, 4 bits: per-byte write enable; bit n covers WRITEDATA[8n+7:8n].
REQ-008 SHALL have port AVL_ADDR, input, 4 bits: word address.
REQ-009 SHALL have port AVL_WRITEDATA, input, 32 bits: write data.
REQ-010 SHALL have port AVL_READDATA, output, 32 bits: read data.
REQ-011 SHALL have port EXPORT_DATA, output, 32 bits: {key word0[31:16], key word3[15:0]}, combinational from the register file.
REQ-012 SHALL have port AES_START, output, 1 bit: start level to the AES core.
REQ-013 SHALL have port AES_DONE, input, 1 bit: done level from the AES core.
REQ-014 SHALL have port AES_KEY, output, 128 bits: snapshotted key to the core.
REQ-015 SHALL have port AES_MSG_ENC, output, 128 bits: snapshotted ciphertext to the core.
REQ-016 SHALL have port AES_MSG_DEC, input, 128 bits: plaintext from the core.

Function
REQ-017 SHALL use this register map: addresses 0-3 KEY, 4-7 ENC and 8-11 DEC (address 0/4/8 = bits [127:96], descending); 12 reserved (reads 0); 13 STATUS (bit0 busy, bit1 done, bit2 timeout); 14 CTRL (bit0 start, bit1 clear done).
REQ-018 SHALL complete a write in one cycle when AVL_CS && AVL_WRITE, honouring AVL_BYTE_EN per byte.
REQ-019 SHALL ignore writes to DEC, STATUS and address 12.
REQ-020 SHALL register AVL_READDATA: value valid the cycle after AVL_CS && AVL_READ, held otherwise.
REQ-021 SHALL implement FSM states IDLE, LOAD, RUN and DRAIN.
REQ-022 IDLE->LOAD SHALL occur on a CTRL write with BYTE_EN[0]=1 and bit0=1; the same write clears STATUS.done and STATUS.timeout.
REQ-023 LOAD SHALL last one cycle, copy KEY and ENC into the AES_KEY and AES_MSG_ENC hold registers, and then enter RUN.
REQ-024 In RUN, AES_START SHALL be 1; AES_START SHALL be 0 in every other state.
REQ-025 RUN->DRAIN SHALL occur on AES_DONE=1; that edge captures AES_MSG_DEC into DEC and sets STATUS.done.
REQ-026 DRAIN SHALL wait for AES_DONE=0 and then go to IDLE.
REQ-027 STATUS.busy SHALL be 1 in LOAD, RUN and DRAIN.
REQ-028 A CTRL start write outside IDLE SHALL be ignored.
REQ-029 KEY/ENC writes while busy SHALL update the register file only; the hold registers and the current operation are unaffected.
REQ-030 A CTRL write with bit1=1 SHALL clear STATUS.done in any state; if this coincides with the done capture, the set wins.
REQ-031 Start-to-AES_START latency SHALL be 2 cycles: write edge, then LOAD edge.

Reset
REQ-032 RESET SHALL asynchronously clear all registers, hold registers, STATUS and AVL_READDATA to 0.
REQ-033 RESET SHALL force the FSM to IDLE and drive AES_START to 0, including mid-operation.
REQ-034 Outputs SHALL be at their reset values on the first edge after RESET falls.

Configuration
REQ-035 With macro AES_TIMEOUT_EN defined, a counter SHALL run in RUN; reaching TIMEOUT_CYCLES without AES_DONE SETS STATUS.timeout, drops AES_START, leaves DEC unchanged and enters IDLE.
REQ-036 With AES_TIMEOUT_EN undefined, there SHALL be no counter, STATUS bit2 reads 0, and RUN waits indefinitely.

Verification
REQ-037 Basic run: KEY=000102030405060708090a0b0c0d0e0f, ENC=daec3055df058e1c39e814ea76f6747e, start; model returns 0123456789abcdeffedcba9876543210 with DONE after 5 cycles -> AES_START high 2 cycles after the write; DEC reads 01234567/89abcdef/fedcba98/76543210; STATUS=2.
REQ-038 Byte enables: write ffffffff to address 0 with BYTE_EN=0101, from 0 -> address 0 reads 00ff00ff; EXPORT_DATA[31:16]=00ff.
REQ-039 Busy isolation: write KEY word0=deadbeef during RUN and issue a second start -> AES_KEY[127:96] stays 00010203, a single operation occurs, and KEY word0 reads deadbeef.
REQ-040 Reset mid-RUN: assert RESET 2 cycles into RUN -> AES_START=0 immediately, STATUS=0, DEC=0.
REQ-041 Timeout (AES_TIMEOUT_EN, TIMEOUT_CYCLES=8): DONE never asserted -> AES_START drops after 8 RUN cycles, STATUS=4, DEC unchanged; the same bench without the macro -> still busy after 100 cycles.
